reg_file_rename: RTL

//  Architectural register file with per-register rename tags. Sits between dispatcher and RoB.

---
 rtl/reg_file_rename_pkg.sv | 24 ++
 rtl/reg_file_rename_if.sv | 41 ++++
 rtl/reg_file_rename_read_port.sv | 34 +++
 rtl/reg_file_rename.sv | 91 +++++++++
 4 files changed

// File: rtl/reg_file_rename_pkg.sv
// Shared widths, tag encoding and small helpers for the rename register file
// and the blocks that exchange rename tags with it (RoB, RS, LSB).
package reg_file_rename_pkg;

    localparam int REG_NUM      = 32;
    localparam int XLEN         = 32;
    localparam int ROB_ID_WIDTH = 5;
    localparam int REG_IDX_W    = $clog2(REG_NUM);

    typedef logic [XLEN-1:0]         data_t;
    typedef logic [ROB_ID_WIDTH-1:0] tag_t;
    typedef logic [REG_IDX_W-1:0]    reg_idx_t;

    // Tag value meaning "value is architecturally valid, no pending producer".
    localparam tag_t     NO_TAG   = 5'd0;
    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam data_t    DATA_ZERO = 32'd0;

    // x0 is hardwired to zero: any access to it is discarded or reads as zero.
    function automatic logic is_zero_reg(input reg_idx_t idx);
        return (idx == REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_file_rename_if.sv
// Dispatcher / RoB facing bus of the rename register file.
// master = the dispatcher+RoB side, slave = the register file.
interface reg_file_rename_if;
    import reg_file_rename_pkg::*;

    logic     rdy_in;
    logic     rollback_flag_in;

    reg_idx_t rs1_from_dispatcher;
    reg_idx_t rs2_from_dispatcher;
    tag_t     Q1_to_dispatcher;
    tag_t     Q2_to_dispatcher;
    data_t    V1_to_dispatcher;
    data_t    V2_to_dispatcher;

    logic     en_rename_from_dispatcher;
    reg_idx_t rd_from_dispatcher;
    tag_t     rob_id_from_dispatcher;

    logic     commit_flag_in;
    reg_idx_t rd_from_rob;
    tag_t     Q_from_rob;
    data_t    V_from_rob;

    modport master (
        output rdy_in, rollback_flag_in,
        output rs1_from_dispatcher, rs2_from_dispatcher,
        input  Q1_to_dispatcher, Q2_to_dispatcher, V1_to_dispatcher, V2_to_dispatcher,
        output en_rename_from_dispatcher, rd_from_dispatcher, rob_id_from_dispatcher,
        output commit_flag_in, rd_from_rob, Q_from_rob, V_from_rob
    );

    modport slave (
        input  rdy_in, rollback_flag_in,
        input  rs1_from_dispatcher, rs2_from_dispatcher,
        output Q1_to_dispatcher, Q2_to_dispatcher, V1_to_dispatcher, V2_to_dispatcher,
        input  en_rename_from_dispatcher, rd_from_dispatcher, rob_id_from_dispatcher,
        input  commit_flag_in, rd_from_rob, Q_from_rob, V_from_rob
    );

endinterface

// File: rtl/reg_file_rename_read_port.sv
// One combinational operand read port: stored value/tag, with the same-cycle
// commit bypass applied when the committing RoB entry is still the newest
// producer of the register.
module reg_file_rename_read_port
    import reg_file_rename_pkg::*;
(
    input  reg_idx_t rs_i,
    input  tag_t     q_stored_i,
    input  data_t    v_stored_i,
    input  logic     commit_flag_i,
    input  reg_idx_t rd_rob_i,
    input  tag_t     q_rob_i,
    input  data_t    v_rob_i,
    output tag_t     q_o,
    output data_t    v_o
);

    // Select x0 zero, commit bypass, or stored entry.
    always_comb begin
        q_o = q_stored_i;
        v_o = v_stored_i;
        if (is_zero_reg(rs_i)) begin
            q_o = NO_TAG;
            v_o = DATA_ZERO;
        end else if (commit_flag_i && (rd_rob_i == rs_i) && (q_stored_i == q_rob_i)) begin
            q_o = NO_TAG;
            v_o = v_rob_i;
        end else begin
            q_o = q_stored_i;
            v_o = v_stored_i;
        end
    end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// Reads are combinational; commits, renames and rollback update state on the
// rising clock edge while rdy_in is high.
module reg_file_rename
    import reg_file_rename_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    reg_file_rename_if.slave    rf
);

    data_t [REG_NUM-1:0] v_q;
    data_t [REG_NUM-1:0] v_d;
    tag_t  [REG_NUM-1:0] q_q;
    tag_t  [REG_NUM-1:0] q_d;

    logic  [REG_NUM-1:0] commit_hit_s;
    logic  [REG_NUM-1:0] rename_hit_s;
    logic                rollback_s;

    // Decode which register (if any) the commit and the rename target this cycle.
    always_comb begin
        rollback_s = rf.rdy_in && rf.rollback_flag_in;
        for (int i = 0; i < REG_NUM; i++) begin
            commit_hit_s[i] = rf.rdy_in && rf.commit_flag_in &&
                              (rf.rd_from_rob == reg_idx_t'(i)) && (i != 0);
            rename_hit_s[i] = rf.rdy_in && !rf.rollback_flag_in &&
                              rf.en_rename_from_dispatcher &&
                              (rf.rd_from_dispatcher == reg_idx_t'(i)) && (i != 0);
        end
    end

    // Next-state: commit writes the value; a younger rename outranks the commit's tag clear; rollback clears every tag.
    always_comb begin
        v_d = v_q;
        q_d = q_q;
        for (int i = 0; i < REG_NUM; i++) begin
            if (commit_hit_s[i]) begin
                v_d[i] = rf.V_from_rob;
            end else begin
                v_d[i] = v_q[i];
            end

            if (rollback_s) begin
                q_d[i] = NO_TAG;
            end else if (rename_hit_s[i]) begin
                q_d[i] = rf.rob_id_from_dispatcher;
            end else if (commit_hit_s[i] && (q_q[i] == rf.Q_from_rob)) begin
                q_d[i] = NO_TAG;
            end else begin
                q_d[i] = q_q[i];
            end
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            v_q <= {REG_NUM{32'd0}};
            q_q <= {REG_NUM{5'd0}};
        end else begin
            v_q <= v_d;
            q_q <= q_d;
        end
    end

    reg_file_rename_read_port u_rd_port1 (
        .rs_i          (rf.rs1_from_dispatcher),
        .q_stored_i    (q_q[rf.rs1_from_dispatcher]),
        .v_stored_i    (v_q[rf.rs1_from_dispatcher]),
        .commit_flag_i (rf.commit_flag_in),
        .rd_rob_i      (rf.rd_from_rob),
        .q_rob_i       (rf.Q_from_rob),
        .v_rob_i       (rf.V_from_rob),
        .q_o           (rf.Q1_to_dispatcher),
        .v_o           (rf.V1_to_dispatcher)
    );

    reg_file_rename_read_port u_rd_port2 (
        .rs_i          (rf.rs2_from_dispatcher),
        .q_stored_i    (q_q[rf.rs2_from_dispatcher]),
        .v_stored_i    (v_q[rf.rs2_from_dispatcher]),
        .commit_flag_i (rf.commit_flag_in),
        .rd_rob_i      (rf.rd_from_rob),
        .q_rob_i       (rf.Q_from_rob),
        .v_rob_i       (rf.V_from_rob),
        .q_o           (rf.Q2_to_dispatcher),
        .v_o           (rf.V2_to_dispatcher)
    );

endmodule
